dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and the address legality check for the two-port data memory arbiter.
// Pure declarations: no timing and no flow control.
package dmem_arb_pkg;

   typedef enum logic {LAST_P0, LAST_P1} arb_state_t;

   localparam int NPORTS = 2;

   // Word-aligned and inside the memory; depth is counted in words.
   function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; grant is combinational (0 cycles), last_grant advances on accept.
// A lone requester always wins; under contention the port not served last wins.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   arb_state_t last_grant_q;
   arb_state_t last_grant_d;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant_q == LAST_P1) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept) begin
         last_grant_d = gnt[0] ? LAST_P0 : LAST_P1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= LAST_P1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_mem between core (P0) and debug/DMA (P1); response one cycle after acceptance.
// Backpressure via req_ready (one grant per cycle, round-robin); illegal requests are accepted but flagged.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_we,
   input  logic [1:0][31:0]       req_addr,
   input  logic [1:0][WIDTH-1:0]  req_wdata,
   output logic [1:0]             resp_valid,
   output logic [WIDTH-1:0]       resp_rdata,
   output logic                   resp_err,
   output logic [31:0]            mem_addr,
   output logic [WIDTH-1:0]       mem_wdata,
   output logic                   mem_write,
   input  logic [WIDTH-1:0]       mem_rdata,
   output logic [1:0][CNT_W-1:0]  acc_cnt
);

   logic [1:0] req_eff;
   logic [1:0] gnt;
   logic       accept;
   logic       sel;
   logic       legal;
   logic       is_write;

   // Masking requests during reset keeps req_ready low and freezes the arbiter.
   assign req_eff = reset ? 2'b00 : req_valid;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req_eff),
      .accept (accept),
      .gnt    (gnt)
   );

   assign accept    = |gnt;
   assign req_ready = gnt;

   // With no grant sel is 0, so the memory bus idles on port 0's request.
   assign sel       = gnt[1];
   assign mem_addr  = req_addr[sel];
   assign mem_wdata = req_wdata[sel];
   assign is_write  = req_we[sel];
   assign legal     = addr_legal(mem_addr, 32'(DEPTH));
   assign mem_write = accept & is_write & legal;

   logic [1:0]       resp_valid_q, resp_valid_d;
   logic             resp_err_q,   resp_err_d;
   logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;

   always_comb begin
      resp_valid_d = gnt;
      resp_err_d   = accept & ~legal;
      resp_rdata_d = (accept & legal & ~is_write) ? mem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 2'b00;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // A response already registered when reset arrives is dropped, not delivered.
   assign resp_valid = reset ? 2'b00 : resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

   logic [NPORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NPORTS; i++) begin
         if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign acc_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_mem and a response scoreboard.
module tb_dmem_arbiter;

   typedef struct {
      logic [1:0]  vld;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [1:0]       vld;
   logic [1:0]       we;
   logic [1:0][31:0] a;
   logic [1:0][31:0] wd;

   logic [1:0]       req_ready,  req_ready_s;
   logic [1:0]       resp_valid, resp_valid_s;
   logic [31:0]      resp_rdata, resp_rdata_s;
   logic             resp_err,   resp_err_s;
   logic [31:0]      mem_addr,   mem_addr_s;
   logic [31:0]      mem_wdata,  mem_wdata_s;
   logic             mem_write,  mem_write_s;
   logic [31:0]      mem_rdata,  mem_rdata_s;
   logic [1:0][15:0] acc_cnt;
   logic [1:0][1:0]  acc_cnt_s;

   logic [31:0] mem   [0:1023];
   logic [31:0] model [0:1023];
   exp_t        sb[$];
   int          tests;
   int          fails;

   dmem_arbiter #(.WIDTH(32), .DEPTH(1024), .CNT_W(16)) dut (
      .clk(clk), .reset(rst), .req_valid(vld), .req_ready(req_ready), .req_we(we),
      .req_addr(a), .req_wdata(wd), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .acc_cnt(acc_cnt)
   );

   // Narrow-counter copy driven by identical stimulus, used for saturation.
   dmem_arbiter #(.WIDTH(32), .DEPTH(1024), .CNT_W(2)) dut_s (
      .clk(clk), .reset(rst), .req_valid(vld), .req_ready(req_ready_s), .req_we(we),
      .req_addr(a), .req_wdata(wd), .resp_valid(resp_valid_s), .resp_rdata(resp_rdata_s),
      .resp_err(resp_err_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
      .mem_write(mem_write_s), .mem_rdata(mem_rdata_s), .acc_cnt(acc_cnt_s)
   );

   // data_mem stand-in: combinational read, junk outside the array, reloaded on reset.
   assign mem_rdata   = (mem_addr[31:12] == 20'd0)   ? mem[mem_addr[11:2]]   : 32'hDEAD_BEEF;
   assign mem_rdata_s = (mem_addr_s[31:12] == 20'd0) ? mem[mem_addr_s[11:2]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 1024; k++) mem[k] <= 32'(k) * 32'd3 + 32'd1;
      end else if (mem_write) begin
         mem[mem_addr[11:2]] <= mem_wdata;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   // One cycle: compare at negedge, push expected responses for accepted requests.
   task automatic tick(input logic [1:0] exp_rdy, input logic exp_mw);
      exp_t e;
      logic lg;
      @(negedge clk);
      if (rst) begin
         check("resp_valid_in_reset", 32'(resp_valid), 32'd0);
         check("req_ready_in_reset", 32'(req_ready), 32'd0);
         sb.delete();
         for (int k = 0; k < 1024; k++) model[k] = 32'(k) * 32'd3 + 32'd1;
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_valid", 32'(resp_valid), 32'(e.vld));
            check("resp_err", 32'(resp_err), 32'(e.err));
            check("resp_rdata", resp_rdata, e.rdata);
         end else begin
            check("resp_valid_idle", 32'(resp_valid), 32'd0);
         end
         check("req_ready", 32'(req_ready), 32'(exp_rdy));
         check("mem_write", 32'(mem_write), 32'(exp_mw));
         for (int i = 0; i < 2; i++) begin
            if (vld[i] && exp_rdy[i]) begin
               lg = (a[i][1:0] == 2'b00) && ({2'b00, a[i][31:2]} < 32'd1024);
               e.vld    = 2'b00;
               e.vld[i] = 1'b1;
               e.err    = !lg;
               e.rdata  = (lg && !we[i]) ? model[a[i][11:2]] : 32'd0;
               if (lg && we[i]) model[a[i][11:2]] = wd[i];
               sb.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1; vld = 2'b11; we = 2'b00;
      a[0] = 32'h0; a[1] = 32'h4; wd[0] = 32'h0; wd[1] = 32'h0;

      // Reset held two cycles with both ports requesting.
      tick(2'b00, 1'b0);
      tick(2'b00, 1'b0);
      check("acc_cnt0_reset", 32'(acc_cnt[0]), 32'd0);
      check("acc_cnt1_reset", 32'(acc_cnt[1]), 32'd0);
      rst = 1'b0;
      tick(2'b01, 1'b0);
      vld = 2'b00;
      tick(2'b00, 1'b0);

      // P0 write 0xAA to 0x8, then read it back.
      vld = 2'b01; we = 2'b01; a[0] = 32'h8; wd[0] = 32'hAA;
      tick(2'b01, 1'b1);
      we = 2'b00;
      tick(2'b01, 1'b0);
      vld = 2'b00;
      tick(2'b00, 1'b0);

      // Sustained contention from a fresh reset.
      rst = 1'b1;
      tick(2'b00, 1'b0);
      rst = 1'b0; vld = 2'b11; we = 2'b00; a[0] = 32'h20; a[1] = 32'h24;
      for (int k = 0; k < 6; k++) tick((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
      vld = 2'b00;
      tick(2'b00, 1'b0);
      check("acc_cnt0_contend", 32'(acc_cnt[0]), 32'd3);
      check("acc_cnt1_contend", 32'(acc_cnt[1]), 32'd3);

      // Illegal accesses from P1: misaligned write, out-of-range read.
      vld = 2'b10; we = 2'b10; a[1] = 32'h6; wd[1] = 32'h55;
      tick(2'b10, 1'b0);
      we = 2'b00; a[1] = 32'h1000;
      tick(2'b10, 1'b0);
      vld = 2'b00;
      tick(2'b00, 1'b0);
      check("mem_word1_untouched", mem[1], model[1]);

      // Cross-port read-after-write on consecutive cycles.
      vld = 2'b01; we = 2'b01; a[0] = 32'h10; wd[0] = 32'hF0;
      tick(2'b01, 1'b1);
      vld = 2'b10; we = 2'b00; a[1] = 32'h10;
      tick(2'b10, 1'b0);
      vld = 2'b00;
      tick(2'b00, 1'b0);

      // Reset in the cycle after an acceptance drops the response.
      vld = 2'b01; we = 2'b00; a[0] = 32'h8;
      tick(2'b01, 1'b0);
      rst = 1'b1; vld = 2'b00;
      tick(2'b00, 1'b0);
      rst = 1'b0;
      tick(2'b00, 1'b0);

      // Five P0 accesses: narrow counter saturates, wide one keeps counting.
      vld = 2'b01; a[0] = 32'hC;
      for (int k = 0; k < 5; k++) tick(2'b01, 1'b0);
      vld = 2'b00;
      tick(2'b00, 1'b0);
      check("acc_cnt0_sat_w2", 32'(acc_cnt_s[0]), 32'd3);
      check("acc_cnt0_w16", 32'(acc_cnt[0]), 32'd5);
      check("acc_cnt1_w16", 32'(acc_cnt[1]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
